// File: rtl/bulls_cows_fsm.sv
// Two-player Bulls & Cows game controller: secret entry, alternating scored guesses, win/draw.
// Optional BULLS_COWS_DISTINCT_CHECK_EN also rejects entries with a repeated digit.
module bulls_cows_fsm #(
    parameter int MAX_GUESSES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        confirm,
    input  logic [15:0] switches,
    output logic [1:0]  phase,
    output logic        turn,
    output logic [2:0]  bulls,
    output logic [2:0]  cows,
    output logic        result_valid,
    output logic        error,
    output logic [1:0]  winner,
    output logic [3:0]  guess_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        SEC1 = 3'd0,
        SEC2 = 3'd1,
        G1   = 3'd2,
        G2   = 3'd3,
        OVER = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] s1, s1_n, s2, s2_n;
    logic [3:0]  cnt1, cnt1_n, cnt2, cnt2_n;
    logic        turn_n, rv_n, error_n;
    logic [2:0]  bulls_n, cows_n;
    logic [1:0]  winner_n;
    logic [15:0] opp_secret;
    logic [2:0]  sc_bulls, sc_cows;
    logic        entry_valid;

    function automatic logic entry_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
`ifdef BULLS_COWS_DISTINCT_CHECK_EN
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
`endif
        return ok;
    endfunction

    // Cows are clamped so bulls+cows never exceeds 4 even if repeated digits were accepted.
    function automatic logic [5:0] score(input logic [15:0] g, input logic [15:0] s);
        logic [2:0] b;
        logic [3:0] c;
        logic [3:0] room;
        b = 3'd0;
        c = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[4*i +: 4] == s[4*i +: 4]) b = b + 3'd1;
            for (int j = 0; j < 4; j++)
                if (i != j && g[4*i +: 4] == s[4*j +: 4]) c = c + 4'd1;
        end
        room = 4'd4 - {1'b0, b};
        if (c > room) c = room;
        return {b, c[2:0]};
    endfunction

    assign entry_valid = entry_ok(switches);
    assign opp_secret  = (state == G2) ? s1 : s2;
    assign {sc_bulls, sc_cows} = score(switches, opp_secret);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= SEC1;
            s1           <= 16'd0;
            s2           <= 16'd0;
            cnt1         <= 4'd0;
            cnt2         <= 4'd0;
            turn         <= 1'b0;
            bulls        <= 3'd0;
            cows         <= 3'd0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            winner       <= 2'b00;
        end else begin
            state        <= state_n;
            s1           <= s1_n;
            s2           <= s2_n;
            cnt1         <= cnt1_n;
            cnt2         <= cnt2_n;
            turn         <= turn_n;
            bulls        <= bulls_n;
            cows         <= cows_n;
            result_valid <= rv_n;
            error        <= error_n;
            winner       <= winner_n;
        end
    end

    always_comb begin
        state_n  = state;
        s1_n     = s1;
        s2_n     = s2;
        cnt1_n   = cnt1;
        cnt2_n   = cnt2;
        turn_n   = turn;
        bulls_n  = bulls;
        cows_n   = cows;
        rv_n     = 1'b0;
        error_n  = error;
        winner_n = winner;
        if (confirm) begin
            if (state == OVER) begin
                state_n  = SEC1;
                s1_n     = 16'd0;
                s2_n     = 16'd0;
                cnt1_n   = 4'd0;
                cnt2_n   = 4'd0;
                turn_n   = 1'b0;
                bulls_n  = 3'd0;
                cows_n   = 3'd0;
                error_n  = 1'b0;
                winner_n = 2'b00;
            end else if (!entry_valid) begin
                error_n = 1'b1;
            end else begin
                error_n = 1'b0;
                case (state)
                    SEC1: begin
                        s1_n    = switches;
                        state_n = SEC2;
                        turn_n  = 1'b1;
                    end
                    SEC2: begin
                        s2_n    = switches;
                        state_n = G1;
                        turn_n  = 1'b0;
                    end
                    G1: begin
                        bulls_n = sc_bulls;
                        cows_n  = sc_cows;
                        rv_n    = 1'b1;
                        cnt1_n  = cnt1 + 4'd1;
                        if (sc_bulls == 3'd4) begin
                            state_n  = OVER;
                            winner_n = 2'b01;
                        end else begin
                            state_n = G2;
                            turn_n  = 1'b1;
                        end
                    end
                    G2: begin
                        bulls_n = sc_bulls;
                        cows_n  = sc_cows;
                        rv_n    = 1'b1;
                        cnt2_n  = cnt2 + 4'd1;
                        // P1 is never ahead by more than one, so the draw is decided here only.
                        if (sc_bulls == 3'd4) begin
                            state_n  = OVER;
                            winner_n = 2'b10;
                        end else if (cnt2_n == 4'(MAX_GUESSES)) begin
                            state_n  = OVER;
                            winner_n = 2'b11;
                        end else begin
                            state_n = G1;
                            turn_n  = 1'b0;
                        end
                    end
                    default: state_n = SEC1;
                endcase
            end
        end
    end

    always_comb begin
        phase = 2'b00;
        case (state)
            G1, G2:  phase = 2'b01;
            OVER:    phase = 2'b10;
            default: phase = 2'b00;
        endcase
    end

    assign guess_count = turn ? cnt2 : cnt1;
    assign state_dbg   = state;

endmodule

// File: tb/tb_bulls_cows_fsm.sv
// Bench for bulls_cows_fsm: directed game scenarios plus randomized play, checked by a
// scoreboard fed from a digit-level game model (honours BULLS_COWS_DISTINCT_CHECK_EN).
module tb_bulls_cows_fsm;
    localparam int TB_MAX = 2;
    localparam int W = 17;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        confirm = 1'b0;
    logic [15:0] switches = 16'd0;
    logic [1:0]  phase;
    logic        turn;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic        result_valid;
    logic        error;
    logic [1:0]  winner;
    logic [3:0]  guess_count;
    logic [2:0]  state_dbg;

    bulls_cows_fsm #(.MAX_GUESSES(TB_MAX)) dut (
        .clock(clock), .reset(reset), .confirm(confirm), .switches(switches),
        .phase(phase), .turn(turn), .bulls(bulls), .cows(cows),
        .result_valid(result_valid), .error(error), .winner(winner),
        .guess_count(guess_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // scoreboard word: phase, turn, bulls, cows, result_valid, error, winner, guess_count
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // game model
    int m_phase, m_turn, m_bulls, m_cows, m_rv, m_err, m_winner;
    int m_sec[2][4];
    int m_cnt[2];

    function automatic bit legal(input logic [15:0] v);
        int d[4];
        for (int i = 0; i < 4; i++) d[i] = int'(v[4*i +: 4]);
        for (int i = 0; i < 4; i++) if (d[i] > 9) return 1'b0;
`ifdef BULLS_COWS_DISTINCT_CHECK_EN
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && d[i] == d[j]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_turn = 0; m_bulls = 0; m_cows = 0;
        m_rv = 0; m_err = 0; m_winner = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) m_sec[p][i] = 0;
    endtask

    task automatic model_step(input logic rst, input logic cf, input logic [15:0] sw);
        int g[4];
        int b, c, t;
        m_rv = 0;
        if (!rst) begin
            model_reset();
        end else if (cf) begin
            for (int i = 0; i < 4; i++) g[i] = int'(sw[4*i +: 4]);
            t = m_turn;
            if (m_phase == 2) begin
                model_reset();
            end else if (!legal(sw)) begin
                m_err = 1;
            end else begin
                m_err = 0;
                if (m_phase == 0) begin
                    for (int i = 0; i < 4; i++) m_sec[t][i] = g[i];
                    if (t == 0) m_turn = 1;
                    else begin m_turn = 0; m_phase = 1; end
                end else begin
                    b = 0; c = 0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            if (g[i] == m_sec[1-t][j]) begin
                                if (i == j) b++; else c++;
                            end
                    m_bulls = b; m_cows = c; m_rv = 1;
                    m_cnt[t]++;
                    if (b == 4) begin
                        m_phase = 2; m_winner = t + 1;
                    end else if (t == 0) begin
                        m_turn = 1;
                    end else if (m_cnt[1] == TB_MAX) begin
                        m_phase = 2; m_winner = 3;
                    end else begin
                        m_turn = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [W-1:0] model_word();
        return {2'(m_phase), 1'(m_turn), 3'(m_bulls), 3'(m_cows), 1'(m_rv), 1'(m_err),
                2'(m_winner), 4'(m_cnt[m_turn])};
    endfunction

    // driver: inputs change on the falling edge; expected post-edge outputs are queued
    task automatic drive(input logic rst, input logic cf, input logic [15:0] sw);
        @(negedge clock);
        reset = rst; confirm = cf; switches = sw;
        model_step(rst, cf, sw);
        exp_q.push_back(model_word());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(posedge clock) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("phase",        int'(phase),        int'(e[16:15]));
            chk("turn",         int'(turn),         int'(e[14]));
            chk("bulls",        int'(bulls),        int'(e[13:11]));
            chk("cows",         int'(cows),         int'(e[10:8]));
            chk("result_valid", int'(result_valid), int'(e[7]));
            chk("error",        int'(error),        int'(e[6]));
            chk("winner",       int'(winner),       int'(e[5:4]));
            chk("guess_count",  int'(guess_count),  int'(e[3:0]));
        end
    end

    function automatic logic [15:0] gen_distinct();
        int pool[10];
        int k, tmp;
        for (int i = 0; i < 10; i++) pool[i] = i;
        for (int i = 9; i > 0; i--) begin
            k = $urandom_range(0, i);
            tmp = pool[i]; pool[i] = pool[k]; pool[k] = tmp;
        end
        return {4'(pool[3]), 4'(pool[2]), 4'(pool[1]), 4'(pool[0])};
    endfunction

    function automatic logic [15:0] gen_bad();
        logic [15:0] v;
        int k;
        v = 16'($urandom);
        k = $urandom_range(0, 3);
        v[4*k +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    function automatic logic [15:0] opp_secret_word();
        int o;
        o = 1 - m_turn;
        return {4'(m_sec[o][3]), 4'(m_sec[o][2]), 4'(m_sec[o][1]), 4'(m_sec[o][0])};
    endfunction

    initial begin
        int r, s;
        logic [15:0] sw;
        model_reset();
        drive(1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);

        // full game, P2 wins; back-to-back guesses
        drive(1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b1, 16'h5678);
        drive(1'b1, 1'b1, 16'h5687);
        drive(1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'h9999);

        // rejected entries in SEC1
        drive(1'b1, 1'b1, 16'h12A4);
        drive(1'b1, 1'b1, 16'h1123);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);

        // draw after TB_MAX guesses each, then restart
        drive(1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b1, 16'h5678);
        for (int i = 0; i < 2 * TB_MAX; i++) drive(1'b1, 1'b1, 16'h9012);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'h4321);

        // reset coincident with a confirm while in G2
        drive(1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b1, 16'h5678);
        drive(1'b1, 1'b1, 16'h5687);
        drive(1'b0, 1'b1, 16'h1234);
        drive(1'b1, 1'b0, 16'h0000);

        // randomized play
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1'b0, 1'($urandom_range(0, 1)), gen_distinct());
            end else if (r < 35) begin
                drive(1'b1, 1'b0, 16'($urandom));
            end else begin
                s = $urandom_range(0, 9);
                if (s == 0) sw = gen_bad();
                else if (s <= 2 && m_phase == 1) sw = opp_secret_word();
                else sw = gen_distinct();
                drive(1'b1, 1'b1, sw);
            end
        end
        drive(1'b1, 1'b0, 16'h0000);

        repeat (4) @(negedge clock);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
